// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// The buffered entry format and the grant encoding used by the top and its FIFO live here.
package rf_wport_arbiter_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        regbits_t wsel;
        word_t    wdat;
    } rfarb_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_BUF,
        GNT_BYP
    } rfarb_gnt_t;

    // Bits needed to index n items. The result is never less than 1, so that
    // degenerate sizes such as a single-entry FIFO still give a legal vector.
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Bundle of the writeback, MDU, hazard-query and register-file write signals.
// The master is the surrounding pipeline/MDU; the slave is the arbiter.
interface rf_wport_arbiter_if #(
    parameter int DEPTH = 2
);
    import rf_wport_arbiter_pkg::*;

    logic                         wb_wen;
    regbits_t                     wb_wsel;
    word_t                        wb_wdat;
    logic                         wb_stall;
    logic                         mdu_valid;
    logic                         mdu_ready;
    regbits_t                     mdu_wsel;
    word_t                        mdu_wdat;
    regbits_t                     q_sel;
    logic                         q_hit;
    logic                         rf_WEN;
    regbits_t                     rf_wsel;
    word_t                        rf_wdat;
    logic [$clog2(DEPTH+1)-1:0]   pend_count;

    modport master (
        output wb_wen, wb_wsel, wb_wdat, mdu_valid, mdu_wsel, mdu_wdat, q_sel,
        input  wb_stall, mdu_ready, q_hit, rf_WEN, rf_wsel, rf_wdat, pend_count
    );

    modport slave (
        input  wb_wen, wb_wsel, wb_wdat, mdu_valid, mdu_wsel, mdu_wdat, q_sel,
        output wb_stall, mdu_ready, q_hit, rf_WEN, rf_wsel, rf_wdat, pend_count
    );

endinterface

// File: rtl/rfarb_fifo.sv
// Circular buffer for MDU results waiting on the register-file write port.
// Entries are flops rather than block RAM: the head is read combinationally and
// every entry's destination is compared in parallel for the hazard query.
module rfarb_fifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        push,
    input  rfarb_entry_t                push_entry,
    input  logic                        pop,
    output rfarb_entry_t                head_entry,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic [DEPTH-1:0]            entry_valid,
    output regbits_t [DEPTH-1:0]        entry_wsel
);
    localparam int PTR_W = bits_for(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rfarb_entry_t       mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [DEPTH-1:0]   valid_reg;
    logic               push_ok;
    logic               pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign count       = count_reg;
    assign entry_valid = valid_reg;
    assign head_entry  = mem_reg[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
            assign entry_wsel[gi] = mem_reg[gi].wsel;
        end
    endgenerate

    // Entry payload storage; no reset needed since valid_reg qualifies it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_entry;
        end
    end

    // Pointers, occupancy and per-slot valid bits. A push and a pop never hit
    // the same slot because a push needs !full and a pop needs !empty.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
        end else begin
            if (push_ok) begin
                valid_reg[wr_ptr_reg] <= 1'b1;
                wr_ptr_reg            <= ptr_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                valid_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg            <= ptr_inc(rd_ptr_reg);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter between the writeback stage and the MDU.
// Writeback has priority; MDU results queue in a small FIFO and drain in idle
// write-port cycles, with a starvation counter forcing a grant (and a one-cycle
// pipeline hold) when the FIFO head has waited too long.
// Optional build macro: RFARB_BYPASS_EN -- an MDU result arriving while the FIFO
// is empty and writeback is idle is written in the same cycle instead of queued.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                CLK,
    input  logic                RST,
    rf_wport_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AGE_W = bits_for(STARVE_LIMIT + 1);

    rfarb_gnt_t             gnt;
    rfarb_entry_t           head_entry;
    rfarb_entry_t           push_entry;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [DEPTH-1:0]       entry_valid;
    regbits_t [DEPTH-1:0]   entry_wsel;
    logic [DEPTH-1:0]       hit_vec;
    logic [AGE_W-1:0]       age_reg;
    logic                   accept;
    logic                   wb_req;
    logic                   forced;

    // Writes to register 0 are architecturally void and never take the port.
    assign wb_req     = bus.wb_wen && (bus.wb_wsel != '0);
    assign accept     = !RST && bus.mdu_valid && !fifo_full;
    assign forced     = !fifo_empty && (age_reg >= AGE_W'(STARVE_LIMIT));
    assign push_entry = '{wsel: bus.mdu_wsel, wdat: bus.mdu_wdat};
    assign fifo_pop   = (gnt == GNT_BUF);
    assign fifo_push  = accept && (bus.mdu_wsel != '0) && (gnt != GNT_BYP);

    rfarb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (CLK),
        .srst        (RST),
        .push        (fifo_push),
        .push_entry  (push_entry),
        .pop         (fifo_pop),
        .head_entry  (head_entry),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count),
        .entry_valid (entry_valid),
        .entry_wsel  (entry_wsel)
    );

    // Grant selection: starved head first, then writeback, then FIFO drain.
    always_comb begin
        gnt = GNT_NONE;
        if (RST) begin
            gnt = GNT_NONE;
        end else if (forced) begin
            gnt = GNT_BUF;
        end else if (wb_req) begin
            gnt = GNT_WB;
        end else if (!fifo_empty) begin
            gnt = GNT_BUF;
`ifdef RFARB_BYPASS_EN
        end else if (accept && (bus.mdu_wsel != '0)) begin
            gnt = GNT_BYP;
`endif
        end
    end

    // Register-file write mux driven by the grant.
    always_comb begin
        bus.rf_WEN  = 1'b0;
        bus.rf_wsel = '0;
        bus.rf_wdat = '0;
        case (gnt)
            GNT_WB: begin
                bus.rf_WEN  = 1'b1;
                bus.rf_wsel = bus.wb_wsel;
                bus.rf_wdat = bus.wb_wdat;
            end
            GNT_BUF: begin
                bus.rf_WEN  = 1'b1;
                bus.rf_wsel = head_entry.wsel;
                bus.rf_wdat = head_entry.wdat;
            end
            GNT_BYP: begin
                bus.rf_WEN  = 1'b1;
                bus.rf_wsel = bus.mdu_wsel;
                bus.rf_wdat = bus.mdu_wdat;
            end
            default: begin
                bus.rf_WEN  = 1'b0;
            end
        endcase
    end

    // Head age: counts denied cycles of the current head, saturating, and
    // restarts whenever an entry leaves or the FIFO runs dry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            age_reg <= '0;
        end else if (fifo_pop || fifo_empty) begin
            age_reg <= '0;
        end else if (age_reg < AGE_W'(STARVE_LIMIT)) begin
            age_reg <= age_reg + AGE_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit_vec[gi] = entry_valid[gi] && (entry_wsel[gi] == bus.q_sel);
        end
    endgenerate

    // A forced grant only costs the pipeline a cycle if writeback wanted the port.
    assign bus.wb_stall   = (gnt == GNT_BUF) && forced && wb_req;
    assign bus.mdu_ready  = !fifo_full;
    assign bus.pend_count = fifo_count;
    assign bus.q_hit      = !RST && (bus.q_sel != '0) && (|hit_vec);

endmodule
